// File: rtl/voice_mixer.sv
// voice_mixer: snapshots the voices on each lrck rise, sums the enabled ones, applies Q4.4 gain and saturates.
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int DATA_W     = 16,
    parameter int GAIN_W     = 8,
    parameter int GAIN_FRAC  = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         lrck,
    input  logic [NUM_VOICES*DATA_W-1:0] voice_in,
    input  logic [NUM_VOICES-1:0]        voice_mask,
    input  logic [GAIN_W-1:0]            gain,
    input  logic                         clr_flags,
    output logic [DATA_W-1:0]            mix_out,
    output logic                         mix_valid,
    output logic                         clip,
    output logic                         overrun
);
    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = DATA_W + IDX_W;
    localparam int PROD_W = ACC_W + GAIN_W + 1;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, SAT} state_t;

    state_t                     state_q, state_d;
    logic                       s1_q, s2_q, s3_q;
    logic signed [DATA_W-1:0]   cap_q [NUM_VOICES];
    logic signed [DATA_W-1:0]   cap_d [NUM_VOICES];
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [GAIN_W-1:0]          gain_q, gain_d;
    logic [DATA_W-1:0]          mix_out_q, mix_out_d;
    logic                       mix_valid_q, mix_valid_d;
    logic                       clip_q, clip_d;
    logic                       overrun_q, overrun_d;
    logic                       edge_det, over, under;
    logic signed [PROD_W-1:0]   shifted;

    assign edge_det = s2_q & ~s3_q;
    // Arithmetic shift floors toward -inf, so tiny negative mixes land on -1
    assign shifted  = prod_q >>> GAIN_FRAC;
    assign over     = shifted > SAT_MAX;
    assign under    = shifted < SAT_MIN;

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        idx_d       = idx_q;
        gain_d      = gain_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        clip_d      = clip_q & ~clr_flags;
        overrun_d   = (overrun_q & ~clr_flags) | (edge_det && state_q != IDLE);
        case (state_q)
            IDLE: if (edge_det) begin
                for (int v = 0; v < NUM_VOICES; v++)
                    cap_d[v] = voice_mask[v] ? voice_in[v*DATA_W +: DATA_W] : '0;
                acc_d   = '0;
                idx_d   = '0;
                gain_d  = gain;
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d   = acc_q + {{(ACC_W-DATA_W){cap_q[idx_q][DATA_W-1]}}, cap_q[idx_q]};
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == IDX_W'(NUM_VOICES - 1)) ? SCALE : ACCUM;
            end
            SCALE: begin
                prod_d  = acc_q * $signed({1'b0, gain_q});
                state_d = SAT;
            end
            SAT: begin
                mix_out_d   = over ? {1'b0, {(DATA_W-1){1'b1}}} :
                              under ? {1'b1, {(DATA_W-1){1'b0}}} : shifted[DATA_W-1:0];
                mix_valid_d = 1'b1;
                clip_d      = clip_d | over | under;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cap_q       <= '{default: '0};
            acc_q       <= '0;
            prod_q      <= '0;
            idx_q       <= '0;
            gain_q      <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= lrck;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            cap_q       <= cap_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            idx_q       <= idx_d;
            gain_q      <= gain_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed vectors, expected samples and pulse cycles queued and checked by a monitor.
module tb_voice_mixer;
    logic         Clk = 1'b0;
    logic         Reset, lrck, clr_flags;
    logic [127:0] voice_in;
    logic [7:0]   voice_mask, gain;
    logic [15:0]  mix_out;
    logic         mix_valid, clip, overrun;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic         prev_valid = 1'b0;

    typedef struct {logic [15:0] val; int at;} exp_t;
    exp_t sb[$];

    always #10 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    voice_mixer dut (
        .Clk(Clk), .Reset(Reset), .lrck(lrck), .voice_in(voice_in),
        .voice_mask(voice_mask), .gain(gain), .clr_flags(clr_flags),
        .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (mix_valid) begin
            chk("valid_width", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("mix_out", {16'd0, mix_out}, {16'd0, e.val});
                chk("latency", cyc, e.at);
            end
        end
        prev_valid <= mix_valid;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < 8; i++) voice_in[16*i +: 16] = v;
    endtask

    // lrck rises now, so the next edge is edge 0 and the pulse follows edge 12
    task automatic mix(input logic [15:0] expv);
        lrck = 1'b1;
        sb.push_back('{expv, cyc + 13});
        repeat (16) tick();
        lrck = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        Reset = 1'b1; lrck = 1'b0; clr_flags = 1'b0;
        voice_in = '0; voice_mask = '0; gain = '0;
        repeat (3) tick();
        chk("rst_mix_out", {16'd0, mix_out}, 32'd0);
        chk("rst_valid", {31'd0, mix_valid}, 32'd0);
        chk("rst_clip", {31'd0, clip}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        Reset = 1'b0;
        repeat (2) tick();

        set_all(16'h0100); voice_mask = 8'hFF; gain = 8'h10;
        mix(16'h0800);
        chk("t1_clip", {31'd0, clip}, 32'd0);

        set_all(16'h1000);
        mix(16'h7FFF);
        chk("t2_clip_pos", {31'd0, clip}, 32'd1);
        set_all(16'h8000);
        mix(16'h8000);
        chk("t2_clip_neg", {31'd0, clip}, 32'd1);
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        chk("t2_clip_clr", {31'd0, clip}, 32'd0);

        voice_in = '0; voice_in[15:0] = 16'hFFF0; voice_mask = 8'h01; gain = 8'h18;
        mix(16'hFFE8);
        voice_mask = 8'h00;
        mix(16'h0000);

        voice_in[15:0] = 16'h0001; voice_mask = 8'h01; gain = 8'h08;
        mix(16'h0000);
        voice_in[15:0] = 16'hFFFF;
        mix(16'hFFFF);
        chk("t4_clip", {31'd0, clip}, 32'd0);

        set_all(16'h0100); voice_mask = 8'hFF; gain = 8'h10;
        lrck = 1'b1;
        sb.push_back('{16'h0800, cyc + 13});
        repeat (5) tick();
        set_all(16'h7FFF); gain = 8'hFF; lrck = 1'b0;
        tick();
        lrck = 1'b1;
        repeat (14) tick();
        lrck = 1'b0;
        repeat (6) tick();
        chk("t5_overrun", {31'd0, overrun}, 32'd1);
        chk("t5_clip", {31'd0, clip}, 32'd0);

        set_all(16'h0100); voice_mask = 8'hFF; gain = 8'h10;
        lrck = 1'b1;
        repeat (7) tick();
        Reset = 1'b1; lrck = 1'b0;
        tick();
        Reset = 1'b0;
        chk("t6_mix_out", {16'd0, mix_out}, 32'd0);
        chk("t6_valid", {31'd0, mix_valid}, 32'd0);
        chk("t6_clip", {31'd0, clip}, 32'd0);
        chk("t6_overrun", {31'd0, overrun}, 32'd0);
        repeat (15) tick();
        set_all(16'h0010); voice_mask = 8'h0F; gain = 8'h20;
        mix(16'h0080);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
- Per-sample mixing stage between the eight Voice outputs and audio_interface. Replaces the plain wrapping 16-bit add.
- Once per DAC frame, it snapshots all voice outputs and accumulates the enabled ones at full width.
- It then applies a master gain, saturates to 16-bit signed and presents one registered sample for LDATA/RDATA.
- Runs on CLOCK_50. The frame strobe is AUD_DACLRCK, synchronised internally.

Parameters:
- NUM_VOICES, 8, number of voice inputs; widths below assume 8.
- DATA_W, 16, signed sample width of each voice and of the output.
- GAIN_W, 8, unsigned master-gain width.
- GAIN_FRAC, 4, fractional bits of gain (Q4.4; 0x10 = unity).

Ports:
- Clk  in  1  system clock (CLOCK_50).
- Reset  in  1  synchronous, active-high reset.
- lrck  in  1  AUD_DACLRCK, asynchronous to Clk; its rising edge starts a mix.
- voice_in  in  128  voice v sample at [16v+15:16v], two's complement.
- voice_mask  in  8  bit v=1 includes voice v in the sum.
- gain  in  8  unsigned Q4.4 master gain.
- clr_flags  in  1  one-cycle pulse; clears clip and overrun.
- mix_out  out  16  mixed, scaled, saturated sample; holds until the next mix.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- clip  out  1  sticky; set when any mix saturated.
- overrun  out  1  sticky; set when an lrck edge arrives while busy.

Behaviour:
- Synchroniser: s1<=lrck, s2<=s1, s3<=s2. edge_det = s2 & ~s3, combinational.
- FSM states:
  - IDLE: on edge_det, load cap[0..7]<=voice_in, gated by voice_mask (masked voices stored as 0); clear acc; idx<=0; go to ACCUM.
  - ACCUM: acc<=acc+cap[idx]; idx++. Stays 8 cycles; at idx==7 go to SCALE.
  - SCALE: prod<=acc * {1'b0,gain}, 19b signed x 9b signed = 28b signed; go to SAT.
  - SAT: shifted=prod>>>4 (arithmetic, floors toward -inf); clamp to [-32768, 32767]; mix_out<=result; mix_valid<=1; go to IDLE.
- Accumulator: 19-bit signed; 8 x 16-bit can never overflow it.
- Clipping: if the clamp is active, clip<=1.
- Latency: call the Clk edge that first samples lrck=1 "edge 0".
  - Capture at edge 2.
  - Accumulations at edges 3-10.
  - prod at edge 11.
  - mix_out and mix_valid update at edge 12, so mix_valid is high for the single cycle following edge 12.
- Snapshot rule: voice_in, voice_mask and gain are sampled at capture (edge 2). gain is latched into gain_q there, so later changes do not affect the mix in flight.
- Busy edge: edge_det while state != IDLE is ignored and overrun<=1. The current mix completes unchanged.
- Flag priority: if clr_flags and a set condition occur in the same cycle, set wins.
- lrck falling edge: no effect.
- Reset values: state=IDLE, s1=s2=s3=0, acc=0, prod=0, cap=0, idx=0, mix_out=0x0000, mix_valid=0, clip=0, overrun=0.
- Reset mid-operation aborts the mix: no mix_valid pulse, mix_out=0.
- lrck held high through reset produces one edge_det after release, because the synchroniser resets to 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. All voices 0x0100, mask 0xFF, gain 0x10, one lrck rise -> mix_out=0x0800. mix_valid is exactly one cycle, following edge 12. clip=0.
2. All voices 0x1000, mask 0xFF, gain 0x10 -> sum 32768 saturates to mix_out=0x7FFF, clip=1. Then all voices 0x8000 -> mix_out=0x8000, clip stays 1. clr_flags -> clip=0.
3. mask 0x01, voice0=0xFFF0 (-16), gain 0x18 -> mix_out=0xFFE8 (-24). mask 0x00 -> mix_out=0x0000.
4. Rounding: voice0=0x0001, mask 0x01, gain 0x08 -> 0x0000. voice0=0xFFFF, gain 0x08 -> 0xFFFF (floor).
5. Change voice_in and gain to 0x7FFF/0xFF at edge 4 of a mix started with 0x0100/0x10 -> result still 0x0800. A second lrck rise at edge 6 -> ignored, overrun=1, only one mix_valid pulse.
6. Assert Reset at edge 7 of a mix -> no mix_valid, mix_out=0, all flags 0. A fresh lrck rise afterwards completes normally with 12-edge latency.
